// File: rtl/alu_muldiv.sv
// Iterative RV32M multiply/divide unit: shift-add multiplier and restoring divider
// sharing one 2*WIDTH accumulator, driven by a start/busy/done handshake with flush.
module alu_muldiv #(
   parameter int WIDTH = 32,
   parameter int CNT_W = 6
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [2:0]       op,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic             flush,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] C
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_CALC = 2'd1,
      S_FIN  = 2'd2
   } state_t;

   localparam logic [WIDTH-1:0] MIN_VAL  = {1'b1, {(WIDTH-1){1'b0}}};
   localparam logic [WIDTH-1:0] ONES     = {WIDTH{1'b1}};
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH-1);

   state_t             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [2:0]         op_q, op_d;
   logic               neg_q, neg_d;
   logic [WIDTH-1:0]   a_q, a_d;
   logic [WIDTH-1:0]   b_q, b_d;
   logic [2*WIDTH-1:0] acc_q, acc_d;
   logic [WIDTH-1:0]   res_q, res_d;
   logic [WIDTH-1:0]   c_q, c_d;

   // Operand decode at the accept edge
   logic               sgn_a, sgn_b, a_neg, b_neg, neg_in;
   logic [WIDTH-1:0]   a_abs, b_abs, sp_res;
   logic               div_zero, ovf, special;

   always_comb begin
      sgn_a    = (op == 3'b001) || (op == 3'b010) || (op == 3'b100) || (op == 3'b110);
      sgn_b    = (op == 3'b001) || (op == 3'b100) || (op == 3'b110);
      a_neg    = sgn_a && A[WIDTH-1];
      b_neg    = sgn_b && B[WIDTH-1];
      a_abs    = a_neg ? -A : A;
      b_abs    = b_neg ? -B : B;
      // Remainder takes the dividend's sign only; everything else uses sign(A)^sign(B)
      neg_in   = a_neg ^ (b_neg && !(op[2] && op[1]));
      div_zero = op[2] && (B == '0);
      ovf      = op[2] && !op[0] && (A == MIN_VAL) && (B == ONES);
      special  = div_zero || ovf;
      if (op[1])
         sp_res = div_zero ? A : '0;
      else
         sp_res = div_zero ? ONES : MIN_VAL;
   end

   // One iteration of each datapath
   logic [WIDTH:0]     mul_sum;
   logic [2*WIDTH-1:0] mul_acc;
   logic [2*WIDTH-1:0] mul_prod;
   logic [WIDTH-1:0]   mul_res;
   logic [WIDTH:0]     trial;
   logic               ge;
   logic [WIDTH-1:0]   diff;
   logic [WIDTH-1:0]   div_rem, div_quo;
   logic [WIDTH-1:0]   div_q_fin, div_r_fin;
   logic [WIDTH-1:0]   calc_res;

   always_comb begin
      mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (b_q[0] ? {1'b0, a_q} : '0);
      mul_acc  = {mul_sum, acc_q[WIDTH-1:1]};
      mul_prod = neg_q ? -mul_acc : mul_acc;
      mul_res  = (op_q[1:0] == 2'b00) ? mul_prod[WIDTH-1:0] : mul_prod[2*WIDTH-1:WIDTH];

      // Partial remainder lives in the accumulator's high half, quotient shifts into a_q
      trial    = {acc_q[2*WIDTH-1:WIDTH], a_q[WIDTH-1]};
      ge       = (trial >= {1'b0, b_q});
      diff     = trial[WIDTH-1:0] - b_q;
      div_rem  = ge ? diff : trial[WIDTH-1:0];
      div_quo  = {a_q[WIDTH-2:0], ge};
      div_q_fin = neg_q ? -div_quo : div_quo;
      div_r_fin = neg_q ? -div_rem : div_rem;

      if (op_q[2])
         calc_res = op_q[1] ? div_r_fin : div_q_fin;
      else
         calc_res = mul_res;
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      op_d    = op_q;
      neg_d   = neg_q;
      a_d     = a_q;
      b_d     = b_q;
      acc_d   = acc_q;
      res_d   = res_q;
      c_d     = c_q;

      case (state_q)
         S_IDLE: begin
            if (start && !flush) begin
               op_d  = op;
               a_d   = a_abs;
               b_d   = b_abs;
               neg_d = neg_in;
               acc_d = '0;
               cnt_d = '0;
               if (special) begin
                  res_d   = sp_res;
                  state_d = S_FIN;
               end else begin
                  state_d = S_CALC;
               end
            end
         end
         S_CALC: begin
            if (flush) begin
               state_d = S_IDLE;
            end else begin
               if (op_q[2]) begin
                  acc_d = {div_rem, acc_q[WIDTH-1:0]};
                  a_d   = div_quo;
               end else begin
                  acc_d = mul_acc;
                  b_d   = {1'b0, b_q[WIDTH-1:1]};
               end
               cnt_d = cnt_q + 1'b1;
               if (cnt_q == LAST_CNT) begin
                  res_d   = calc_res;
                  state_d = S_FIN;
               end
            end
         end
         S_FIN: begin
            state_d = S_IDLE;
            // A flushed result is never published
            if (!flush)
               c_d = res_q;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         op_q    <= '0;
         neg_q   <= 1'b0;
         a_q     <= '0;
         b_q     <= '0;
         acc_q   <= '0;
         res_q   <= '0;
         c_q     <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         op_q    <= op_d;
         neg_q   <= neg_d;
         a_q     <= a_d;
         b_q     <= b_d;
         acc_q   <= acc_d;
         res_q   <= res_d;
         c_q     <= c_d;
      end
   end

   always_comb begin
      busy = (state_q != S_IDLE);
      done = (state_q == S_FIN) && !flush;
      C    = done ? res_q : c_q;
   end

endmodule

// File: tb/tb_alu_muldiv.sv
// Bench for alu_muldiv: table of RV32M vectors, random ops against a 64-bit reference,
// and hand-written flush / reset / ignored-start sequences.
module tb_alu_muldiv;
   localparam int W = 32;
   localparam int LONG = W + 1;

   logic         clk = 1'b0;
   logic         rst, start, flush;
   logic [2:0]   op;
   logic [W-1:0] a, b;
   logic         busy, done;
   logic [W-1:0] c_out;

   int           n_checks = 0;
   int           n_fail = 0;
   logic [W-1:0] exp_q[$];
   logic [W-1:0] last_c = '0;

   alu_muldiv #(.WIDTH(W), .CNT_W(6)) dut (
      .clk(clk), .rst(rst), .start(start), .op(op), .A(a), .B(b),
      .flush(flush), .busy(busy), .done(done), .C(c_out)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [2:0]   op;
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic [W-1:0] exp;
      int           lat;
      int           poke;
   } vec_t;

   task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   function automatic logic [W-1:0] model(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
      logic signed [63:0] sx, sy, ux, uy, p;
      logic signed [W-1:0] q;
      logic [W-1:0] r;
      logic [W-1:0] min_v;
      logic ov;
      sx = {{32{x[31]}}, x};
      sy = {{32{y[31]}}, y};
      ux = {32'b0, x};
      uy = {32'b0, y};
      min_v = 32'h8000_0000;
      ov = (x == min_v) && (y == 32'hFFFF_FFFF);
      r = '0;
      case (o)
         3'd0: begin p = ux * uy; r = p[31:0]; end
         3'd1: begin p = sx * sy; r = p[63:32]; end
         3'd2: begin p = sx * uy; r = p[63:32]; end
         3'd3: begin p = ux * uy; r = p[63:32]; end
         3'd4: begin
            if (y == 0) r = 32'hFFFF_FFFF;
            else if (ov) r = min_v;
            else begin q = $signed(x) / $signed(y); r = q; end
         end
         3'd5: r = (y == 0) ? 32'hFFFF_FFFF : x / y;
         3'd6: begin
            if (y == 0) r = x;
            else if (ov) r = '0;
            else begin q = $signed(x) % $signed(y); r = q; end
         end
         default: r = (y == 0) ? x : x % y;
      endcase
      return r;
   endfunction

   function automatic int latency(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
      if (o[2] && ((y == 0) || (!o[0] && x == 32'h8000_0000 && y == 32'hFFFF_FFFF)))
         return 1;
      return LONG;
   endfunction

   // Issue one op, push its expected result, then wait (bounded) for done.
   // poke>0 drives a junk start in that cycle after accept; it must be ignored.
   task automatic run_op(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                         input logic [W-1:0] exp, input int lat, input int poke, input string name);
      int cyc;
      int busy_cyc;
      bit seen;
      @(negedge clk);
      op = o; a = x; b = y; start = 1'b1;
      exp_q.push_back(exp);
      @(posedge clk); #1;
      start = 1'b0;
      cyc = 0; busy_cyc = 0; seen = 1'b0;
      while (!seen && cyc < 200) begin
         @(negedge clk);
         cyc++;
         if (busy) busy_cyc++;
         if (done) begin
            seen = 1'b1;
            check({name, " latency"}, cyc, lat);
            check({name, " busy cycles"}, busy_cyc, lat);
            if (exp_q.size() == 0) begin
               n_checks++; n_fail++;
               $display("FAIL %s: done with empty expected queue", name);
            end else begin
               check({name, " C"}, c_out, exp_q.pop_front());
            end
            last_c = exp;
         end
         if (cyc == poke) begin
            start = 1'b1; op = 3'b101; a = $urandom; b = $urandom_range(1, 1000);
            @(posedge clk); #1;
            start = 1'b0;
         end
      end
      if (!seen) begin
         n_checks++; n_fail++;
         $display("FAIL %s: no done within 200 cycles, got none expected 1", name);
         exp_q.delete();
      end
      if (poke == lat) begin
         @(negedge clk);
         check({name, " start in FIN ignored (busy)"}, busy, 1'b0);
      end
   endtask

   vec_t vecs[$];

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int dones;
      logic [2:0] ro;
      logic [W-1:0] ra, rb;

      vecs.push_back('{3'd0, 32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB, LONG, 5});
      vecs.push_back('{3'd1, 32'h8000_0000,  32'h8000_0000, 32'h4000_0000, LONG, 0});
      vecs.push_back('{3'd3, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE, LONG, 0});
      vecs.push_back('{3'd2, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFF, LONG, 0});
      vecs.push_back('{3'd4, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD, LONG, 0});
      vecs.push_back('{3'd6, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF, LONG, 0});
      vecs.push_back('{3'd5, 32'd100,        32'd7,         32'd14,        LONG, 0});
      vecs.push_back('{3'd5, 32'd1000,       32'd10,        32'd100,       LONG, 0});
      vecs.push_back('{3'd7, 32'd100,        32'd7,         32'd2,         LONG, 0});
      vecs.push_back('{3'd5, 32'd5,          32'd0,         32'hFFFF_FFFF, 1,    1});
      vecs.push_back('{3'd6, 32'd5,          32'd0,         32'd5,         1,    0});
      vecs.push_back('{3'd4, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 1,    0});
      vecs.push_back('{3'd6, 32'h8000_0000,  32'hFFFF_FFFF, 32'd0,         1,    0});
      vecs.push_back('{3'd0, 32'd0,          32'd12345,     32'd0,         LONG, 0});
      vecs.push_back('{3'd5, 32'hFFFF_FFFF,  32'd1,         32'hFFFF_FFFF, LONG, LONG});
      vecs.push_back('{3'd7, 32'd123,        32'd0,         32'd123,       1,    0});

      rst = 1'b1; start = 1'b0; flush = 1'b0; op = '0; a = '0; b = '0;
      repeat (2) @(negedge clk);
      check("reset busy", busy, 1'b0);
      check("reset done", done, 1'b0);
      check("reset C", c_out, '0);
      rst = 1'b0;

      foreach (vecs[i])
         run_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp, vecs[i].lat, vecs[i].poke,
                $sformatf("vec%0d", i));

      for (int i = 0; i < 10; i++) begin
         ro = 3'($urandom_range(0, 7));
         ra = $urandom;
         rb = ($urandom_range(0, 5) == 0) ? 32'd0 : $urandom;
         run_op(ro, ra, rb, model(ro, ra, rb), latency(ro, ra, rb), 0, $sformatf("rand%0d", i));
      end

      // Flush at CALC cycle 10: no done, C keeps the last published value
      @(negedge clk);
      op = 3'd5; a = 32'd100; b = 32'd7; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (10) @(negedge clk);
      flush = 1'b1;
      #1 check("flush cycle done", done, 1'b0);
      @(posedge clk); #1;
      flush = 1'b0;
      @(negedge clk);
      check("flush busy after", busy, 1'b0);
      check("flush C held", c_out, last_c);
      dones = 0;
      repeat (40) begin
         @(negedge clk);
         if (done) dones++;
      end
      check("flush no done pulse", dones, 0);
      check("flush C still held", c_out, last_c);

      // flush together with start in IDLE: nothing is accepted
      @(negedge clk);
      op = 3'd0; a = 32'd3; b = 32'd4; start = 1'b1; flush = 1'b1;
      @(posedge clk); #1;
      start = 1'b0; flush = 1'b0;
      @(negedge clk);
      check("flush+start busy", busy, 1'b0);

      // Asynchronous reset mid-CALC
      run_op(3'd0, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, LONG, 0, "pre-reset mul");
      @(negedge clk);
      op = 3'd3; a = 32'd9; b = 32'd9; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (5) @(negedge clk);
      check("mid-calc busy before rst", busy, 1'b1);
      #2 rst = 1'b1;
      #1;
      check("async rst busy", busy, 1'b0);
      check("async rst done", done, 1'b0);
      check("async rst C", c_out, '0);
      repeat (2) @(negedge clk);
      rst = 1'b0;
      last_c = '0;
      dones = 0;
      repeat (40) begin
         @(negedge clk);
         if (done) dones++;
      end
      check("no done after rst", dones, 0);
      check("C zero after rst", c_out, '0);

      run_op(3'd5, 32'd100, 32'd7, 32'd14, LONG, 0, "post-reset divu");
      run_op(3'd7, 32'd100, 32'd7, 32'd2, LONG, 0, "post-reset remu");

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
